// File: rtl/mandala_pkg.sv
// Shared types and defaults for the mandala animation sequencer.
package mandala_pkg;

    // Sequencer states; encodings are fixed so debug taps read consistently.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        PAUSED    = 2'd1,
        STEP_PEND = 2'd2
    } anim_state_t;

    localparam int PHASE_W_DEF = 10;
    localparam int COLOR_W_DEF = 8;

    // True for every state that the user sees as "paused".
    function automatic logic is_paused_state(input anim_state_t s);
        return (s == PAUSED) || (s == STEP_PEND);
    endfunction

endpackage

// File: rtl/mandala_anim_ctrl_if.sv
// Control/phase bundle between the frame source, user controls and the
// animation sequencer. master = stimulus/consumer side, slave = sequencer.
interface mandala_anim_ctrl_if #(
    parameter int PHASE_W = 10,
    parameter int COLOR_W = 8
);
    logic               vsync;
    logic [2:0]         speed;
    logic               dir;
    logic               pause;
    logic               step;
    logic [PHASE_W-1:0] pattern_phase;
    logic [COLOR_W-1:0] color_phase;
    logic               frame_tick;
    logic               paused;
    logic [15:0]        frame_count;

    modport master (
        output vsync, speed, dir, pause, step,
        input  pattern_phase, color_phase, frame_tick, paused, frame_count
    );

    modport slave (
        input  vsync, speed, dir, pause, step,
        output pattern_phase, color_phase, frame_tick, paused, frame_count
    );
endinterface

// File: rtl/mandala_anim_ctrl_sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture of pins that are asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/mandala_anim_ctrl.sv
// Frame-synchronous animation sequencer: advances pattern/colour phases only
// on a vsync rise so the downstream pattern stage never tears mid-frame.
module mandala_anim_ctrl
    import mandala_pkg::*;
#(
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int COLOR_W    = COLOR_W_DEF,
    parameter int PHASE_STEP = 1,
    parameter int COLOR_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    mandala_anim_ctrl_if.slave  bus
);
    localparam int                  CDIV_W     = (COLOR_DIV > 1) ? $clog2(COLOR_DIV) : 1;
    localparam logic [CDIV_W-1:0]   CDIV_LAST  = CDIV_W'(COLOR_DIV - 1);
    localparam logic [CDIV_W-1:0]   CDIV_ONE   = CDIV_W'(32'd1);
    localparam logic [PHASE_W-1:0]  PSTEP      = PHASE_W'(PHASE_STEP);
    localparam logic [COLOR_W-1:0]  COLOR_ONE  = COLOR_W'(32'd1);

    // Synchronised user controls.
    logic [5:0]         sync_q_s;
    logic [2:0]         speed_sync_s;
    logic               dir_sync_s;
    logic               pause_sync_s;
    logic               step_sync_s;
    logic               step_d_r;
    logic               step_rise_s;

    // Frame detection.
    logic               vsync_d_r;
    logic               tick_s;

    // Sequencer state and counters.
    anim_state_t        state_r;
    anim_state_t        state_next_s;
    logic [2:0]         div_cnt_r;
    logic [2:0]         div_next_s;
    logic               advance_s;
    logic [CDIV_W-1:0]  col_div_r;

    // Output registers.
    logic [PHASE_W-1:0] pattern_phase_r;
    logic [COLOR_W-1:0] color_phase_r;
    logic               frame_tick_r;
    logic               paused_r;
    logic [15:0]        frame_count_r;

    sync2 #(.W(6)) u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     ({bus.speed, bus.dir, bus.pause, bus.step}),
        .q     (sync_q_s)
    );

    assign speed_sync_s = sync_q_s[5:3];
    assign dir_sync_s   = sync_q_s[2];
    assign pause_sync_s = sync_q_s[1];
    assign step_sync_s  = sync_q_s[0];

    assign tick_s      = bus.vsync & ~vsync_d_r;
    assign step_rise_s = step_sync_s & ~step_d_r;

    // Edge-detect registers. vsync_d resets high so that a vsync already
    // asserted when reset drops is not mistaken for a fresh frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d_r <= 1'b1;
            step_d_r  <= 1'b0;
        end else begin
            vsync_d_r <= bus.vsync;
            step_d_r  <= step_sync_s;
        end
    end

    // Next-state, divider and advance decision.
    always_comb begin
        state_next_s = state_r;
        div_next_s   = div_cnt_r;
        advance_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (tick_s) begin
                    if (pause_sync_s) begin
                        state_next_s = PAUSED;
                        div_next_s   = 3'd0;
                    end else if (div_cnt_r >= speed_sync_s) begin
                        advance_s    = 1'b1;
                        div_next_s   = 3'd0;
                    end else begin
                        div_next_s   = div_cnt_r + 3'd1;
                    end
                end else begin
                    div_next_s = div_cnt_r;
                end
            end
            PAUSED: begin
                // Release wins over a coincident step; ticks never advance here.
                if (!pause_sync_s) begin
                    state_next_s = RUN;
                    div_next_s   = 3'd0;
                end else if (step_rise_s) begin
                    state_next_s = STEP_PEND;
                end else begin
                    state_next_s = PAUSED;
                end
            end
            STEP_PEND: begin
                // Exactly one advance at the next frame; extra steps are dropped.
                if (tick_s) begin
                    advance_s    = 1'b1;
                    div_next_s   = 3'd0;
                    state_next_s = pause_sync_s ? PAUSED : RUN;
                end else begin
                    state_next_s = STEP_PEND;
                end
            end
            default: begin
                state_next_s = RUN;
                div_next_s   = 3'd0;
            end
        endcase
    end

    // State and frame-divider register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= RUN;
            div_cnt_r <= 3'd0;
        end else begin
            state_r   <= state_next_s;
            div_cnt_r <= div_next_s;
        end
    end

    // Phase advance; direction is taken from dir as seen on the advancing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_phase_r <= {PHASE_W{1'b0}};
            color_phase_r   <= {COLOR_W{1'b0}};
            col_div_r       <= {CDIV_W{1'b0}};
        end else if (advance_s) begin
            if (dir_sync_s) begin
                pattern_phase_r <= pattern_phase_r - PSTEP;
            end else begin
                pattern_phase_r <= pattern_phase_r + PSTEP;
            end
            if (col_div_r == CDIV_LAST) begin
                col_div_r <= {CDIV_W{1'b0}};
                if (dir_sync_s) begin
                    color_phase_r <= color_phase_r - COLOR_ONE;
                end else begin
                    color_phase_r <= color_phase_r + COLOR_ONE;
                end
            end else begin
                col_div_r <= col_div_r + CDIV_ONE;
            end
        end
    end

    // Frame pulse, frame counter and paused flag (decoded from next state so
    // it always equals the state register decode, with no input path).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick_r  <= 1'b0;
            frame_count_r <= 16'd0;
            paused_r      <= 1'b0;
        end else begin
            frame_tick_r <= tick_s;
            paused_r     <= is_paused_state(state_next_s);
            if (tick_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

    assign bus.pattern_phase = pattern_phase_r;
    assign bus.color_phase   = color_phase_r;
    assign bus.frame_tick    = frame_tick_r;
    assign bus.paused        = paused_r;
    assign bus.frame_count   = frame_count_r;
endmodule

// File: tb/tb_mandala_anim_ctrl.sv
// Directed bench for the mandala animation sequencer.
module tb_mandala_anim_ctrl;
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       dir   = 1'b0;
    logic       pause = 1'b0;
    logic       step  = 1'b0;

    int n_cmp    = 0;
    int n_err    = 0;
    int tick_cnt = 0;
    int base     = 0;

    mandala_anim_ctrl_if #(.PHASE_W(10), .COLOR_W(8)) bus ();

    assign bus.vsync = vsync;
    assign bus.speed = speed;
    assign bus.dir   = dir;
    assign bus.pause = pause;
    assign bus.step  = step;

    mandala_anim_ctrl #(
        .PHASE_W    (10),
        .COLOR_W    (8),
        .PHASE_STEP (1),
        .COLOR_DIV  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count every cycle frame_tick is seen high.
    always @(negedge clk) begin
        if (bus.frame_tick === 1'b1) tick_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_frame();
        @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset(input logic vs);
        @(negedge clk);
        reset = 1'b1;
        vsync = vs;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // ---- reset held through 3 vsync pulses ----
        repeat (3) run_frame();
        check_val("rst_phase", 32'(bus.pattern_phase), 32'd0);
        check_val("rst_color", 32'(bus.color_phase), 32'd0);
        check_val("rst_fcnt", 32'(bus.frame_count), 32'd0);
        check_val("rst_tick", 32'(bus.frame_tick), 32'd0);
        check_val("rst_paused", 32'(bus.paused), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        base = tick_cnt;
        repeat (4) @(negedge clk);

        // first frame: tick and phase update land on the same edge
        @(negedge clk);
        vsync = 1'b1;
        check_val("pre_tick", 32'(bus.frame_tick), 32'd0);
        check_val("pre_phase", 32'(bus.pattern_phase), 32'd0);
        @(negedge clk);
        check_val("tick_hi", 32'(bus.frame_tick), 32'd1);
        check_val("tick_phase", 32'(bus.pattern_phase), 32'd1);
        @(negedge clk);
        check_val("tick_lo", 32'(bus.frame_tick), 32'd0);
        repeat (1) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        repeat (4) run_frame();
        check_val("run5_phase", 32'(bus.pattern_phase), 32'd5);
        check_val("run5_color", 32'(bus.color_phase), 32'd1);
        check_val("run5_fcnt", 32'(bus.frame_count), 32'd5);
        check_val("run5_ticks", 32'(tick_cnt - base), 32'd5);

        // ---- divider: speed 3 advances every 4th frame ----
        speed = 3'd3;
        apply_reset(1'b0);
        for (int f = 1; f <= 12; f++) begin
            run_frame();
            check_val($sformatf("div_f%0d", f), 32'(bus.pattern_phase), 32'(f / 4));
        end
        check_val("div_color", 32'(bus.color_phase), 32'd0);

        // ---- reverse wrap ----
        speed = 3'd0;
        dir   = 1'b1;
        apply_reset(1'b0);
        run_frame();
        check_val("rev1_phase", 32'(bus.pattern_phase), 32'd1023);
        check_val("rev1_color", 32'(bus.color_phase), 32'd0);
        repeat (3) run_frame();
        check_val("rev4_phase", 32'(bus.pattern_phase), 32'd1020);
        check_val("rev4_color", 32'(bus.color_phase), 32'd255);

        // ---- pause and single step ----
        dir = 1'b0;
        apply_reset(1'b0);
        repeat (7) run_frame();
        check_val("ps_run7", 32'(bus.pattern_phase), 32'd7);
        check_val("ps_color", 32'(bus.color_phase), 32'd1);
        pause = 1'b1;
        repeat (4) @(negedge clk);
        repeat (3) run_frame();
        check_val("ps_hold", 32'(bus.pattern_phase), 32'd7);
        check_val("ps_paused", 32'(bus.paused), 32'd1);
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            repeat (3) @(negedge clk);
            step = 1'b0;
            repeat (3) @(negedge clk);
        end
        check_val("ps_pend", 32'(bus.pattern_phase), 32'd7);
        run_frame();
        check_val("ps_step1", 32'(bus.pattern_phase), 32'd8);
        run_frame();
        check_val("ps_noqueue", 32'(bus.pattern_phase), 32'd8);
        check_val("ps_paused2", 32'(bus.paused), 32'd1);

        // ---- step rise coincident with tick ----
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        step  = 1'b0;
        repeat (4) @(negedge clk);
        check_val("col_step_tick", 32'(bus.pattern_phase), 32'd8);
        run_frame();
        check_val("col_step_next", 32'(bus.pattern_phase), 32'd9);

        // ---- pause release coincident with tick ----
        @(negedge clk);
        pause = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        check_val("col_rel_tick", 32'(bus.pattern_phase), 32'd9);
        check_val("col_rel_paused", 32'(bus.paused), 32'd0);
        run_frame();
        check_val("col_rel_next", 32'(bus.pattern_phase), 32'd10);
        check_val("col_rel_color", 32'(bus.color_phase), 32'd2);

        // direction change applies at the next advance
        dir = 1'b1;
        repeat (4) @(negedge clk);
        run_frame();
        check_val("dir_flip", 32'(bus.pattern_phase), 32'd9);
        dir = 1'b0;

        // ---- async reset mid-run ----
        apply_reset(1'b0);
        repeat (300) run_frame();
        check_val("mid_phase", 32'(bus.pattern_phase), 32'd300);
        check_val("mid_fcnt", 32'(bus.frame_count), 32'd300);
        check_val("mid_color", 32'(bus.color_phase), 32'd75);
        @(negedge clk);
        vsync = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_val("ar_phase", 32'(bus.pattern_phase), 32'd0);
        check_val("ar_color", 32'(bus.color_phase), 32'd0);
        check_val("ar_fcnt", 32'(bus.frame_count), 32'd0);
        check_val("ar_paused", 32'(bus.paused), 32'd0);
        check_val("ar_tick", 32'(bus.frame_tick), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base  = tick_cnt;
        repeat (6) @(negedge clk);
        check_val("ar_vs_high_ticks", 32'(tick_cnt - base), 32'd0);
        check_val("ar_vs_high_fcnt", 32'(bus.frame_count), 32'd0);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        run_frame();
        check_val("ar_first_ticks", 32'(tick_cnt - base), 32'd1);
        check_val("ar_first_phase", 32'(bus.pattern_phase), 32'd1);
        check_val("ar_first_fcnt", 32'(bus.frame_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
